// File: rtl/lab2_input_stage.sv
// lab2_input_stage: front end for the three-input combinational lab stage.
// Board switches are synchronized and debounced (MANUAL mode), or the block
// walks through all eight operand combinations on its own (SWEEP mode).
// The chosen operands are registered onto x1/x2/x3, and changes are flagged.

module lab2_input_stage #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SWEEP_DIV       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sw,
  input  logic       sweep_en,
  output logic       x1,
  output logic       x2,
  output logic       x3,
  output logic       changed,
  output logic       sweep_wrap,
  output logic       mode
);

  // Counters only ever need to reach their terminal value minus one.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DW = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SWEEP_DIV - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    SWEEP  = 1'b1
  } state_t;

  logic [2:0]         swMeta_q;
  logic [2:0]         swSync_q;
  logic               sweepMeta_q;
  logic               sweepSync_q;

  logic [2:0][CW-1:0] dbCount_q;
  logic [2:0][CW-1:0] dbCount_d;
  logic [2:0]         stable_q;
  logic [2:0]         stable_d;

  state_t             state_q;
  state_t             state_d;
  logic [2:0]         sweepCnt_q;
  logic [2:0]         sweepCnt_d;
  logic [DW-1:0]      div_q;
  logic [DW-1:0]      div_d;
  logic               sweepWrap_d;

  logic [2:0]         xSel_d;
  logic [2:0]         x_q;
  logic               changed_q;
  logic               changed_d;
  logic               sweepWrap_q;

  // Two-flop synchronizers; the first stage feeds nothing but the second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swMeta_q    <= '0;
      swSync_q    <= '0;
      sweepMeta_q <= 1'b0;
      sweepSync_q <= 1'b0;
    end else begin
      swMeta_q    <= sw;
      swSync_q    <= swMeta_q;
      sweepMeta_q <= sweep_en;
      sweepSync_q <= sweepMeta_q;
    end
  end

  // Per-bit debounce: count disagreeing cycles, flip the stable bit on the last one.
  always_comb begin
    stable_d  = stable_q;
    dbCount_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (swSync_q[i] != stable_q[i]) begin
        if (dbCount_q[i] == CNT_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          dbCount_d[i] = dbCount_q[i] + CW'(1);
        end
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q  <= '0;
      dbCount_q <= '0;
    end else begin
      stable_q  <= stable_d;
      dbCount_q <= dbCount_d;
    end
  end

  // Mode FSM plus sweep divider/counter; leaving SWEEP throws the count away.
  always_comb begin
    state_d     = state_q;
    sweepCnt_d  = sweepCnt_q;
    div_d       = div_q;
    sweepWrap_d = 1'b0;
    case (state_q)
      MANUAL: begin
        if (sweepSync_q) begin
          state_d    = SWEEP;
          sweepCnt_d = 3'b000;
          div_d      = '0;
        end
      end
      SWEEP: begin
        if (!sweepSync_q) begin
          state_d    = MANUAL;
          sweepCnt_d = 3'b000;
          div_d      = '0;
        end else if (div_q == DIV_LAST) begin
          div_d       = '0;
          sweepCnt_d  = sweepCnt_q + 3'd1;
          sweepWrap_d = (sweepCnt_q == 3'b111);
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: begin
        state_d = MANUAL;
      end
    endcase
  end

  // FSM and sweep state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MANUAL;
      sweepCnt_q <= 3'b000;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      sweepCnt_q <= sweepCnt_d;
      div_q      <= div_d;
    end
  end

  // Operand source select and change detection against the current outputs.
  always_comb begin
    xSel_d    = (state_q == SWEEP) ? sweepCnt_q : stable_q;
    changed_d = (xSel_d != x_q);
  end

  // Registered operands and the one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= 3'b000;
      changed_q   <= 1'b0;
      sweepWrap_q <= 1'b0;
    end else begin
      x_q         <= xSel_d;
      changed_q   <= changed_d;
      sweepWrap_q <= sweepWrap_d;
    end
  end

  assign {x1, x2, x3} = x_q;
  assign changed      = changed_q;
  assign sweep_wrap   = sweepWrap_q;
  assign mode         = (state_q == SWEEP);

endmodule

// File: tb/tb_lab2_input_stage.sv
// tb_lab2_input_stage: drives a default instance and a fast (1,1) instance
// with the same inputs and compares both against a window/arithmetic model.

module tb_lab2_input_stage;

  logic       clk;
  logic       rst;
  logic [2:0] sw;
  logic       sweep_en;

  logic aX1, aX2, aX3, aChanged, aWrap, aMode;
  logic bX1, bX2, bX3, bChanged, bWrap, bMode;

  int testsRun;
  int failCount;
  int changedCountA;
  int wrapCountA;
  logic found;

  // Model state: index 0 = default instance, index 1 = fast instance.
  int         dbc[2];
  int         dvs[2];
  logic [2:0] stableM[2];
  logic [2:0] xM[2];
  logic       modeM[2];
  logic       changedM[2];
  logic       wrapM[2];
  int         cntM[2];
  int         entryM[2];
  int         edgeN;
  logic [2:0] swHist[$];
  logic       seHist[$];

  lab2_input_stage dutA (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .sweep_en   (sweep_en),
    .x1         (aX1),
    .x2         (aX2),
    .x3         (aX3),
    .changed    (aChanged),
    .sweep_wrap (aWrap),
    .mode       (aMode)
  );

  lab2_input_stage #(
    .DEBOUNCE_CYCLES (1),
    .SWEEP_DIV       (1)
  ) dutB (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .sweep_en   (sweep_en),
    .x1         (bX1),
    .x2         (bX2),
    .x3         (bX3),
    .changed    (bChanged),
    .sweep_wrap (bWrap),
    .mode       (bMode)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    edgeN = 0;
    swHist.delete();
    seHist.delete();
    for (int k = 0; k < 20; k++) begin
      swHist.push_back(3'b000);
      seHist.push_back(1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      stableM[i]  = 3'b000;
      xM[i]       = 3'b000;
      modeM[i]    = 1'b0;
      changedM[i] = 1'b0;
      wrapM[i]    = 1'b0;
      cntM[i]     = 0;
      entryM[i]   = 0;
    end
  endtask

  // One rising edge of the reference: a switch bit is accepted once the
  // synchronized input (input two edges ago) has disagreed with it for the
  // whole last-D window; the sweep value is elapsed-edges/DIV modulo 8.
  task automatic modelEdge();
    int         last;
    logic [2:0] xNew;
    logic [2:0] stNew;
    logic [2:0] past;
    logic       mNew;
    logic       allDiff;
    int         cNew;
    edgeN++;
    swHist.push_back(sw);
    seHist.push_back(sweep_en);
    while (swHist.size() > 40) begin
      void'(swHist.pop_front());
      void'(seHist.pop_front());
    end
    last = swHist.size() - 1;
    for (int i = 0; i < 2; i++) begin
      xNew  = modeM[i] ? 3'(cntM[i]) : stableM[i];
      stNew = stableM[i];
      for (int b = 0; b < 3; b++) begin
        allDiff = 1'b1;
        for (int j = 0; j < dbc[i]; j++) begin
          past = swHist[last - 2 - j];
          if (past[b] == stableM[i][b]) allDiff = 1'b0;
        end
        if (allDiff) stNew[b] = ~stableM[i][b];
      end
      mNew = seHist[last - 2];
      if (mNew && !modeM[i]) entryM[i] = edgeN;
      cNew = mNew ? (((edgeN - entryM[i]) / dvs[i]) % 8) : 0;
      wrapM[i]    = modeM[i] && mNew && (cntM[i] == 7) && (cNew == 0);
      changedM[i] = (xNew != xM[i]);
      xM[i]       = xNew;
      stableM[i]  = stNew;
      modeM[i]    = mNew;
      cntM[i]     = cNew;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " a.x"},       {aX1, aX2, aX3},     xM[0]);
    checkOutput({tag, " a.changed"}, {2'b00, aChanged},   {2'b00, changedM[0]});
    checkOutput({tag, " a.wrap"},    {2'b00, aWrap},      {2'b00, wrapM[0]});
    checkOutput({tag, " a.mode"},    {2'b00, aMode},      {2'b00, modeM[0]});
    checkOutput({tag, " b.x"},       {bX1, bX2, bX3},     xM[1]);
    checkOutput({tag, " b.changed"}, {2'b00, bChanged},   {2'b00, changedM[1]});
    checkOutput({tag, " b.wrap"},    {2'b00, bWrap},      {2'b00, wrapM[1]});
    checkOutput({tag, " b.mode"},    {2'b00, bMode},      {2'b00, modeM[1]});
  endtask

  task automatic applyStimulus(input logic [2:0] swVal, input logic seVal, input int nEdges);
    sw       = swVal;
    sweep_en = seVal;
    repeat (nEdges) begin
      @(posedge clk);
      modelEdge();
      #1;
      checkAll("edge");
      if (aChanged === 1'b1) changedCountA++;
      if (aWrap === 1'b1) wrapCountA++;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll("resetImm");
    repeat (2) begin
      @(posedge clk);
      #1;
      checkAll("inReset");
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] rs;
    logic       re;
    int         len;
    testsRun      = 0;
    failCount     = 0;
    changedCountA = 0;
    wrapCountA    = 0;
    found         = 1'b0;
    dbc[0] = 16; dvs[0] = 8;
    dbc[1] = 1;  dvs[1] = 1;
    rst      = 1'b0;
    sw       = 3'b000;
    sweep_en = 1'b0;
    modelReset();

    doReset();

    // Clean step 000 -> 101: nothing through edge 18, new value on edge 19.
    changedCountA = 0;
    applyStimulus(3'b101, 1'b0, 18);
    checkOutput("step101 before19", {aX1, aX2, aX3}, 3'b000);
    applyStimulus(3'b101, 1'b0, 1);
    checkOutput("step101 at19", {aX1, aX2, aX3}, 3'b101);
    checkOutput("step101 pulse", {2'b00, aChanged}, 3'b001);
    applyStimulus(3'b101, 1'b0, 10);
    checkOutput("step101 onePulse", 3'(changedCountA), 3'd1);

    // Reach 111, then reset mid-cycle and watch the recovery with sw held.
    applyStimulus(3'b111, 1'b0, 25);
    checkOutput("pre-reset x", {aX1, aX2, aX3}, 3'b111);
    doReset();
    checkOutput("post-reset x", {aX1, aX2, aX3}, 3'b000);
    applyStimulus(3'b111, 1'b0, 3);
    checkOutput("fast before4", {bX1, bX2, bX3}, 3'b000);
    applyStimulus(3'b111, 1'b0, 1);
    checkOutput("fast at4", {bX1, bX2, bX3}, 3'b111);
    checkOutput("fast pulse", {2'b00, bChanged}, 3'b001);
    applyStimulus(3'b111, 1'b0, 14);
    checkOutput("reset111 before19", {aX1, aX2, aX3}, 3'b000);
    applyStimulus(3'b111, 1'b0, 1);
    checkOutput("reset111 at19", {aX1, aX2, aX3}, 3'b111);
    checkOutput("reset111 pulse", {2'b00, aChanged}, 3'b001);

    // Fifteen-cycle glitch on sw[1] must be rejected by the default instance.
    applyStimulus(3'b000, 1'b0, 25);
    changedCountA = 0;
    applyStimulus(3'b010, 1'b0, 15);
    applyStimulus(3'b000, 1'b0, 25);
    checkOutput("glitch x2", {2'b00, aX2}, 3'b000);
    checkOutput("glitch noPulse", 3'(changedCountA), 3'd0);

    // Full sweep with sw=011: nine changes and one wrap in 70 edges.
    applyStimulus(3'b011, 1'b0, 25);
    changedCountA = 0;
    wrapCountA    = 0;
    applyStimulus(3'b011, 1'b1, 70);
    checkOutput("sweep changes", 4'(changedCountA) > 4'd7 ? 3'(changedCountA - 8) : 3'd7, 3'd1);
    checkOutput("sweep wraps", 3'(wrapCountA), 3'd1);
    checkOutput("sweep mode", {2'b00, aMode}, 3'b001);

    // Drop sweep_en while showing 100; expect 011 and exactly one pulse.
    for (int k = 0; k < 100 && !found; k++) begin
      applyStimulus(3'b011, 1'b1, 1);
      if ({aX1, aX2, aX3} === 3'b100) found = 1'b1;
    end
    checkOutput("reach100", {2'b00, found}, 3'b001);
    changedCountA = 0;
    applyStimulus(3'b011, 1'b0, 4);
    checkOutput("exit x", {aX1, aX2, aX3}, 3'b011);
    checkOutput("exit mode", {2'b00, aMode}, 3'b000);
    checkOutput("exit pulses", 3'(changedCountA), 3'd1);
    applyStimulus(3'b011, 1'b1, 4);
    checkOutput("reenter x", {aX1, aX2, aX3}, 3'b000);
    checkOutput("reenter mode", {2'b00, aMode}, 3'b001);
    applyStimulus(3'b011, 1'b1, 10);

    // Randomized segments, with occasional mid-cycle resets.
    for (int seg = 0; seg < 40; seg++) begin
      rs  = 3'($urandom_range(0, 7));
      re  = ($urandom_range(0, 3) == 0) ? ~sweep_en : sweep_en;
      len = $urandom_range(1, 25);
      if ($urandom_range(0, 11) == 0) doReset();
      applyStimulus(rs, re, len);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
